// File: rtl/sdram_read_arbiter.sv
// Round-robin owner of the single SDRAM read master.
// Grants one requester, issues its read command, counts beats, pulses done.
module sdram_read_arbiter #(
    parameter  int NUM_PORTS = 32,
    parameter  int ADDR_W    = 32,
    parameter  int LEN_W     = 11,
    localparam int SEL_W     = $clog2(NUM_PORTS)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        enable,
    input  logic [NUM_PORTS-1:0]        req,
    input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
    input  logic [NUM_PORTS*LEN_W-1:0]  req_len,
    output logic [NUM_PORTS-1:0]        gnt,
    output logic [SEL_W-1:0]            sel,
    output logic                        cmd_valid,
    input  logic                        cmd_ready,
    output logic [ADDR_W-1:0]           cmd_addr,
    output logic [LEN_W-1:0]            cmd_len,
    input  logic                        rd_valid,
    output logic [NUM_PORTS-1:0]        done,
    output logic                        busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CMD  = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]           r_state;
    logic [SEL_W-1:0]     r_ptr;
    logic [LEN_W-1:0]     r_cnt;
    logic [NUM_PORTS-1:0] r_gnt;
    logic [SEL_W-1:0]     r_sel;
    logic [ADDR_W-1:0]    r_addr;
    logic [LEN_W-1:0]     r_len;

    logic                 w_found;
    logic [SEL_W-1:0]     w_pick;
    logic [SEL_W-1:0]     w_idx;
    logic [ADDR_W-1:0]    w_pick_addr;
    logic [LEN_W-1:0]     w_pick_len;

    // First requester at or after the rr pointer, wrapping around.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            w_idx = r_ptr + SEL_W'(k);
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    assign w_pick_addr = req_addr[int'(w_pick)*ADDR_W +: ADDR_W];
    assign w_pick_len  = req_len[int'(w_pick)*LEN_W +: LEN_W];

    // Transfer sequencing; grant and command fields are frozen for the whole burst.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_cnt   <= '0;
            r_gnt   <= '0;
            r_sel   <= '0;
            r_addr  <= '0;
            r_len   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (enable && w_found) begin
                        r_gnt   <= NUM_PORTS'(1) << w_pick;
                        r_sel   <= w_pick;
                        r_addr  <= w_pick_addr;
                        r_len   <= w_pick_len;
                        r_state <= (w_pick_len == '0) ? S_DONE : S_CMD;
                    end
                end
                S_CMD: begin
                    if (cmd_ready) begin
                        r_cnt   <= '0;
                        r_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (rd_valid) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == r_len - 1'b1) begin
                            r_state <= S_DONE;
                        end
                    end
                end
                default: begin
                    r_ptr   <= r_sel + 1'b1;
                    r_gnt   <= '0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign sel       = r_sel;
    assign cmd_valid = (r_state == S_CMD);
    assign cmd_addr  = r_addr;
    assign cmd_len   = r_len;
    assign done      = (r_state == S_DONE) ? r_gnt : '0;
    assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_sdram_read_arbiter.sv
// Randomized bench for sdram_read_arbiter against a
// transaction-level round-robin model.
module tb_sdram_read_arbiter;

    localparam int N  = 32;
    localparam int AW = 32;
    localparam int LW = 11;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            enable;
    logic [N-1:0]    req;
    logic [N*AW-1:0] req_addr;
    logic [N*LW-1:0] req_len;
    logic [N-1:0]    gnt;
    logic [4:0]      sel;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [AW-1:0]   cmd_addr;
    logic [LW-1:0]   cmd_len;
    logic            rd_valid;
    logic [N-1:0]    done;
    logic            busy;

    sdram_read_arbiter #(
        .NUM_PORTS(N),
        .ADDR_W   (AW),
        .LEN_W    (LW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .req      (req),
        .req_addr (req_addr),
        .req_len  (req_len),
        .gnt      (gnt),
        .sel      (sel),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_addr (cmd_addr),
        .cmd_len  (cmd_len),
        .rd_valid (rd_valid),
        .done     (done),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int            n_cmp = 0;
    int            n_err = 0;
    int            m_ptr = 0;
    logic [AW-1:0] p_addr [N];
    logic [LW-1:0] p_len  [N];

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] m, input int p);
        for (int k = 0; k < N; k++) begin
            if (m[(p + k) % N]) return (p + k) % N;
        end
        return 0;
    endfunction

    task automatic pack();
        for (int i = 0; i < N; i++) begin
            req_addr[i*AW +: AW] = p_addr[i];
            req_len[i*LW +: LW]  = p_len[i];
        end
    endtask

    task automatic wait_gnt(output bit got);
        got = 1'b0;
        for (int t = 0; t < 6 && !got; t++) begin
            @(negedge clk);
            if (gnt != '0) got = 1'b1;
        end
    endtask

    task automatic do_txn(input logic [N-1:0] mask, input int bp,
                          input bit drop_en);
        int          w;
        int          given;
        bit          got;
        logic [63:0] oh;
        req       = mask;
        enable    = 1'b1;
        cmd_ready = 1'b0;
        rd_valid  = 1'b0;
        w  = pick(mask, m_ptr);
        oh = 64'(1) << w;
        wait_gnt(got);
        if (!got) begin
            chk("grant_timeout", gnt, oh);
            return;
        end
        chk("gnt", gnt, oh);
        chk("sel", sel, w);
        chk("cmd_addr", cmd_addr, p_addr[w]);
        chk("cmd_len", cmd_len, p_len[w]);
        chk("busy_on", busy, 1);
        if (drop_en) enable = 1'b0;
        if (p_len[w] == '0) begin
            chk("len0_no_cmd", cmd_valid, 0);
            chk("len0_done", done, oh);
        end else begin
            chk("cmd_valid", cmd_valid, 1);
            chk("no_early_done", done, 0);
            for (int i = 0; i < bp; i++) begin
                rd_valid = 1'($urandom_range(0, 1));
                @(negedge clk);
                chk("bp_valid", cmd_valid, 1);
                chk("bp_addr", cmd_addr, p_addr[w]);
                chk("bp_len", cmd_len, p_len[w]);
            end
            cmd_ready = 1'b1;
            rd_valid  = 1'($urandom_range(0, 1));
            @(negedge clk);
            cmd_ready = 1'b0;
            chk("accepted", cmd_valid, 0);
            given = 0;
            while (given < int'(p_len[w])) begin
                rd_valid = 1'($urandom_range(0, 1));
                if (rd_valid) given++;
                req = mask & N'($urandom);
                @(negedge clk);
                if (given < int'(p_len[w])) chk("beat_no_done", done, 0);
            end
            rd_valid = 1'b0;
            chk("done", done, oh);
            chk("done_gnt", gnt, oh);
        end
        @(negedge clk);
        chk("done_pulse", done, 0);
        chk("gnt_clr", gnt, 0);
        chk("busy_off", busy, 0);
        m_ptr = (w + 1) % N;
        if (drop_en) begin
            req = mask;
            @(negedge clk);
            chk("en_block", gnt, 0);
        end
        enable = 1'b1;
    endtask

    task automatic reset_mid_data();
        bit got;
        p_len[9] = 11'd4;
        pack();
        req       = N'(1) << 9;
        enable    = 1'b1;
        cmd_ready = 1'b0;
        rd_valid  = 1'b0;
        wait_gnt(got);
        chk("rst_gnt", gnt, 64'(1) << 9);
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        rd_valid  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rd_valid = 1'b0;
        chk("rst_pre_done", done, 0);
        rst_n = 1'b0;
        #1;
        chk("rst_gnt0", gnt, 0);
        chk("rst_sel0", sel, 0);
        chk("rst_cmdv0", cmd_valid, 0);
        chk("rst_addr0", cmd_addr, 0);
        chk("rst_len0", cmd_len, 0);
        chk("rst_done0", done, 0);
        chk("rst_busy0", busy, 0);
        req = '0;
        @(negedge clk);
        rst_n = 1'b1;
        m_ptr = 0;
        rd_valid = 1'b1;
        @(negedge clk);
        rd_valid = 1'b0;
        chk("rst_no_done", done, 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        enable    = 1'b0;
        req       = '0;
        cmd_ready = 1'b0;
        rd_valid  = 1'b0;
        for (int i = 0; i < N; i++) begin
            p_addr[i] = $urandom;
            p_len[i]  = LW'($urandom_range(1, 5));
        end
        pack();
        repeat (3) @(negedge clk);
        chk("reset_gnt", gnt, 0);
        chk("reset_busy", busy, 0);
        chk("reset_cmdv", cmd_valid, 0);
        chk("reset_done", done, 0);
        rst_n = 1'b1;
        @(negedge clk);

        p_addr[3] = 32'h1000;
        p_len[3]  = 11'd4;
        pack();
        do_txn(N'(1) << 3, 2, 1'b0);

        for (int i = 0; i < N; i++) p_len[i] = 11'd1;
        pack();
        for (int i = 0; i < 33; i++) do_txn('1, 0, 1'b0);

        for (int i = 0; i < N; i++) p_len[i] = LW'($urandom_range(1, 4));
        pack();
        do_txn(N'(1) << 30, 1, 1'b0);
        do_txn((N'(1) << 31) | N'(1), 0, 1'b0);
        do_txn((N'(1) << 31) | N'(1), 0, 1'b0);

        p_len[5] = 11'd0;
        pack();
        do_txn(N'(1) << 5, 0, 1'b0);

        p_len[7] = 11'd4;
        pack();
        do_txn(N'(1) << 7, 10, 1'b0);

        req    = '1;
        enable = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("enable_low", gnt, 0);
        end

        do_txn(N'(1) << 20, 1, 1'b1);
        reset_mid_data();
        do_txn((N'(1) << 25) | N'(1), 0, 1'b0);

        for (int it = 0; it < 40; it++) begin
            logic [N-1:0] m;
            for (int i = 0; i < N; i++) begin
                p_addr[i] = $urandom;
                p_len[i]  = LW'($urandom_range(0, 5));
            end
            pack();
            m = N'($urandom);
            if (m == '0) m = N'(1);
            do_txn(m, $urandom_range(0, 3), ($urandom_range(0, 3) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
